// File: rtl/tpu_pkg.sv
// Shared definitions for the dot-product unit.
// Holds the readout FSM state type and the sign-magnitude field helpers
// (sign-bit index and magnitude width as a function of operand width).
package tpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_PRESENT = 2'd2
  } rd_state_t;

  // Sign-magnitude operand layout: MSB is the sign, the rest is magnitude.
  function automatic int sm_sign_idx(input int data_w);
    return data_w - 1;
  endfunction

  function automatic int sm_mag_w(input int data_w);
    return data_w - 1;
  endfunction

endpackage

// File: rtl/tpu_sm_mult.sv
// Single-lane sign-magnitude multiplier (combinational).
// Ports:
//   a, b : DATA_W-bit sign-magnitude operands
//   mag  : unsigned product magnitude, 2*(DATA_W-1) bits
//   sign : product sign; forced to 0 when the magnitude is zero so that
//          -0 operands and zero products always come out as +0
module tpu_sm_mult
  import tpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0]                a,
  input  logic [DATA_W-1:0]                b,
  output logic [2*sm_mag_w(DATA_W)-1:0]    mag,
  output logic                             sign
);

  localparam int MW = sm_mag_w(DATA_W);
  localparam int SI = sm_sign_idx(DATA_W);

  logic [2*MW-1:0] a_ext;
  logic [2*MW-1:0] b_ext;

  assign a_ext = {{MW{1'b0}}, a[MW-1:0]};
  assign b_ext = {{MW{1'b0}}, b[MW-1:0]};
  assign mag   = a_ext * b_ext;
  assign sign  = (a[SI] ^ b[SI]) & (|mag);

endmodule

// File: rtl/tpu_dot_unit.sv
// Pipelined sign-magnitude dot-product accumulator with a readout FSM.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid / in_ready : operand beat handshake
//   in_a, in_b          : LANES packed sign-magnitude operands, lane 0 in LSBs
//   acc_clear           : zero accumulator and error (clear-then-add)
//   out_req             : request a readout (honoured only in IDLE)
//   out_valid, out_data : one-cycle readout pulse and held readout value
//   error               : sticky overflow flag
// Pipeline: stage 1 registers per-lane products, stage 2 registers the
// signed lane sum, and the accumulator adds stage 2 on the next edge.
module tpu_dot_unit
  import tpu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int LANES    = 4,
  parameter int ACC_W    = 17,
  parameter int SATURATE = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_a,
  input  logic [LANES*DATA_W-1:0]   in_b,
  input  logic                      acc_clear,
  input  logic                      out_req,
  output logic                      out_valid,
  output logic [ACC_W-1:0]          out_data,
  output logic                      error
);

  localparam int MW    = sm_mag_w(DATA_W);
  localparam int PW    = 2 * MW;
  localparam int SUM_W = PW + $clog2(LANES) + 1;
  // One bit wider than either addend so acc + sum is always exact.
  localparam int EXT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;

  rd_state_t state, state_next;

  logic                    accept;
  logic [PW-1:0]           m_mag  [LANES];
  logic [LANES-1:0]        m_sign;
  logic [PW-1:0]           s1_mag [LANES];
  logic [LANES-1:0]        s1_sign;
  logic                    s1_valid;
  logic signed [SUM_W-1:0] lane_sum;
  logic signed [SUM_W-1:0] s2_sum;
  logic                    s2_valid;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [EXT_W-1:0] ext_sum;
  logic                    ovf;
  logic                    err_base;
  logic                    err_next;

  assign accept = in_valid & in_ready;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    tpu_sm_mult #(.DATA_W(DATA_W)) u_mult (
      .a    (in_a[g*DATA_W +: DATA_W]),
      .b    (in_b[g*DATA_W +: DATA_W]),
      .mag  (m_mag[g]),
      .sign (m_sign[g])
    );
  end

  // Stage 1: per-lane product registers. acc_clear deliberately leaves these alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sign  <= '0;
      for (int i = 0; i < LANES; i++) s1_mag[i] <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_sign <= m_sign;
        for (int i = 0; i < LANES; i++) s1_mag[i] <= m_mag[i];
      end
    end
  end

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      if (s1_sign[i]) lane_sum = lane_sum - $signed(SUM_W'(s1_mag[i]));
      else            lane_sum = lane_sum + $signed(SUM_W'(s1_mag[i]));
    end
  end

  // Stage 2: registered lane sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_sum   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_sum <= lane_sum;
    end
  end

  // Accumulate. A clear on the same edge as an add yields just the add,
  // and the error flag then reflects only that add.
  always_comb begin
    acc_base = acc_clear ? '0 : acc;
    err_base = acc_clear ? 1'b0 : error;
    ext_sum  = EXT_W'(acc_base) + EXT_W'(s2_sum);
    // Out of range when the bits above the ACC_W sign bit disagree with it.
    ovf      = (|ext_sum[EXT_W-1:ACC_W-1]) & ~(&ext_sum[EXT_W-1:ACC_W-1]);
    acc_next = acc_base;
    err_next = err_base;
    if (s2_valid) begin
      err_next = err_base | ovf;
      if (ovf && (SATURATE != 0))
        acc_next = ext_sum[EXT_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                    : {1'b0, {(ACC_W-1){1'b1}}};
      else
        acc_next = ext_sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      error <= 1'b0;
    end else begin
      acc   <= acc_next;
      error <= err_next;
    end
  end

  // Readout FSM.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (out_req) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!s1_valid && !s2_valid) state_next = ST_PRESENT;
      end
      ST_PRESENT: begin
        out_valid  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Capture the accumulator as it will be during PRESENT (a clear on the
  // entry edge is honoured); held until the next readout.
  always_ff @(posedge clk) begin
    if (reset)                         out_data <= '0;
    else if (state_next == ST_PRESENT) out_data <= acc_next;
  end

endmodule

// File: tb/tb_tpu_dot_unit.sv
// Self-checking bench for tpu_dot_unit (LANES=4, DATA_W=8, ACC_W=17, SATURATE=1).
// A behavioural model tracks accepted beats as dot products that land in the
// accumulator two edges after acceptance, plus the readout request state.
module tb_tpu_dot_unit;

  localparam int DATA_W = 8;
  localparam int LANES  = 4;
  localparam int ACC_W  = 17;
  localparam longint AMAX = (longint'(1) <<< (ACC_W-1)) - 1;
  localparam longint AMIN = -(longint'(1) <<< (ACC_W-1));

  logic clk = 1'b0;
  logic reset, in_valid, acc_clear, out_req;
  logic [LANES*DATA_W-1:0] in_a, in_b;
  logic in_ready, out_valid, error;
  logic [ACC_W-1:0] out_data;

  always #5 clk = ~clk;

  tpu_dot_unit #(.DATA_W(DATA_W), .LANES(LANES), .ACC_W(ACC_W), .SATURATE(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .acc_clear(acc_clear), .out_req(out_req),
    .out_valid(out_valid), .out_data(out_data), .error(error)
  );

  int total = 0;
  int bad   = 0;

  longint m_acc, m_out;
  bit     m_err, m_drain, m_present;
  longint pq_sum[$];
  int     pq_rem[$];

  bit     pulse_seen;
  longint pulse_val;
  bit     pulse_err;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sm_val(input logic [7:0] x);
    return x[7] ? -longint'(x[6:0]) : longint'(x[6:0]);
  endfunction

  function automatic longint dot(input logic [31:0] a, input logic [31:0] b);
    longint s = 0;
    for (int i = 0; i < LANES; i++) s += sm_val(a[i*8 +: 8]) * sm_val(b[i*8 +: 8]);
    return s;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_out = 0; m_err = 0; m_drain = 0; m_present = 0;
    pq_sum.delete(); pq_rem.delete();
  endtask

  // Called just after a falling edge with inputs already driven: check outputs,
  // advance one rising edge, update the model, return after the next falling edge.
  task automatic step();
    bit busy, accepted, empty, ovf;
    longint base, t, nd;
    bit eb;
    chk("in_ready",  in_ready,  !(m_drain || m_present));
    chk("out_valid", out_valid, m_present);
    chk("out_data",  $signed(out_data), m_out);
    chk("error",     error,     m_err);
    if (out_valid === 1'b1) begin
      pulse_seen = 1;
      pulse_val  = longint'($signed(out_data));
      pulse_err  = error;
    end
    busy     = m_drain || m_present;
    accepted = in_valid && !busy;
    empty    = (pq_sum.size() == 0);
    nd       = dot(in_a, in_b);
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      base = acc_clear ? 0 : m_acc;
      eb   = acc_clear ? 0 : m_err;
      foreach (pq_rem[i]) pq_rem[i]--;
      if (pq_rem.size() > 0 && pq_rem[0] == 0) begin
        t   = base + pq_sum[0];
        ovf = (t > AMAX) || (t < AMIN);
        m_acc = (t > AMAX) ? AMAX : (t < AMIN) ? AMIN : t;
        m_err = eb | ovf;
        void'(pq_sum.pop_front());
        void'(pq_rem.pop_front());
      end else begin
        m_acc = base;
        m_err = eb;
      end
      if (m_present) m_present = 0;
      else if (m_drain && empty) begin
        m_drain = 0; m_present = 1; m_out = m_acc;
      end else if (!m_drain && out_req) m_drain = 1;
      if (accepted) begin
        pq_sum.push_back(nd);
        pq_rem.push_back(2);
      end
    end
    @(negedge clk);
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] b);
    in_valid = 1; in_a = a; in_b = b;
    step();
    in_valid = 0;
  endtask

  task automatic wait_pulse(input string name, input longint exp_val, input bit exp_err);
    for (int i = 0; i < 10 && !pulse_seen; i++) step();
    chk({name, "_pulse"}, pulse_seen, 1);
    chk({name, "_val"}, pulse_val, exp_val);
    chk({name, "_err"}, pulse_err, exp_err);
  endtask

  task automatic readout(input string name, input longint exp_val, input bit exp_err);
    pulse_seen = 0;
    out_req = 1;
    step();
    out_req = 0; in_valid = 0;
    wait_pulse(name, exp_val, exp_err);
  endtask

  function automatic logic [7:0] rnd_op();
    int r = $urandom_range(0, 15);
    if (r < 3)  return 8'h7F;
    if (r < 5)  return 8'hFF;
    if (r == 5) return 8'h80;
    if (r == 6) return 8'h00;
    return 8'($urandom);
  endfunction

  initial begin
    reset = 1; in_valid = 0; acc_clear = 0; out_req = 0; in_a = '0; in_b = '0;
    pulse_seen = 0; pulse_val = 0; pulse_err = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    step();
    reset = 0;
    chk("rst_out_data", $signed(out_data), 0);
    chk("rst_error", error, 0);
    chk("rst_in_ready", in_ready, 1);

    // Basic beat and readout
    beat(32'h0000_000D, 32'h0000_000F);
    readout("r195", 195, 0);

    // Accumulation continues across readouts; negative product
    beat(32'h0000_0029, 32'h0000_002F);
    readout("r2122", 2122, 0);
    beat(32'h0000_0089, 32'h0000_0009);
    readout("r2041", 2041, 0);

    // Positive saturation, then clear
    acc_clear = 1; step(); acc_clear = 0;
    beat(32'h7F7F_7F7F, 32'h7F7F_7F7F);
    beat(32'h7F7F_7F7F, 32'h7F7F_7F7F);
    readout("sat", 65535, 1);
    acc_clear = 1; step(); acc_clear = 0;
    readout("clr", 0, 0);

    // Clear-then-add while a 1x1 beat sits in stage 2; -0 lane contributes +0
    beat(32'h0000_0001, 32'h0000_0001);
    step();
    acc_clear = 1; step(); acc_clear = 0;
    beat(32'h0000_8089, 32'h0000_0589);
    readout("clr_add", 82, 0);

    // Beat accepted in the same cycle as out_req is included; in_ready low in DRAIN
    pulse_seen = 0;
    in_valid = 1; in_a = 32'h0000_0003; in_b = 32'h0000_0004; out_req = 1;
    step();
    in_valid = 0; out_req = 0;
    chk("drain_in_ready", in_ready, 0);
    wait_pulse("same_cyc", 94, 0);

    // Reset in the middle of a DRAIN
    pulse_seen = 0;
    in_valid = 1; in_a = 32'h0000_0002; in_b = 32'h0000_0002; out_req = 1;
    step();
    in_valid = 0; out_req = 0; reset = 1;
    step();
    reset = 0;
    chk("drain_rst_in_ready", in_ready, 1);
    chk("drain_rst_out_data", $signed(out_data), 0);
    repeat (6) step();
    chk("drain_rst_no_pulse", pulse_seen, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      acc_clear = ($urandom_range(0, 39) == 0);
      out_req   = ($urandom_range(0, 7) == 0);
      for (int l = 0; l < LANES; l++) begin
        in_a[l*8 +: 8] = rnd_op();
        in_b[l*8 +: 8] = rnd_op();
      end
      step();
    end
    reset = 0; in_valid = 0; acc_clear = 0; out_req = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
